axis_video_frame_sink: RTL
==========================

// Module: axis_video_frame_sink
// PURPOSE
//  Synthesizable AXI4-Stream video receiver; the consuming end of the pixel stream the Hough
//  pipeline emits. Accepts one frame per SOF (tuser), checks line framing (tlast), counts
//  frames and accumulates a pixel checksum so on-chip output can be checked without a file dump.
// PARAMETERS
//  IMG_WIDTH      640  pixels per line (>=2)
//  IMG_HEIGHT     480  lines per frame (>=1)
//  IO_DATA_WIDTH  24   tdata width (<=32)
// PORTS
//  ap_clk         in   1              clock, all logic rising-edge
//  areset         in   1              asynchronous reset, active-high
//  s_axis_tdata   in   IO_DATA_WIDTH  pixel data
//  s_axis_tvalid  in   1              beat valid
//  s_axis_tready  out  1              sink ready (registered)
//  s_axis_tlast   in   1              end of line
//  s_axis_tuser   in   1              start of frame, pixel (0,0)
//  throttle       in   1              backpressure request (used only with AXIS_SINK_THROTTLE_EN)
//  frame_done     out  1              1-cycle pulse, frame completed
//  frame_err      out  1              OR of err_code
//  err_code       out  3              [0] early EOL, [1] missing EOL, [2] SOF restart
//  frame_count    out  16             completed frames, wraps 0xFFFF->0
//  pix_checksum   out  32             sum of accepted tdata (zero-extended) mod 2^32, current frame
// BEHAVIOUR
//  - Beat = tvalid & tready on rising edge. All outputs registered.
//  - Reset (async, any time incl. mid-frame): state IDLE, tready 0, frame_done 0, err_code 0,
//    frame_count 0, pix_checksum 0, x/y counters 0. tready goes 1 first edge after release.
//  - IDLE: tready 1. Beats with tuser=0 discarded (no counter/checksum effect). Beat with tuser=1:
//    err_code<=0, pix_checksum<=tdata, x<=1 (or line end handled as below), y<=0 -> ACTIVE.
//  - ACTIVE: each beat adds tdata to pix_checksum, x++.
//    * Line end at x==IMG_WIDTH-1: tlast=1 normal; tlast=0 sets err_code[1]. x<=0, y++.
//    * tlast=1 at x<IMG_WIDTH-1: sets err_code[0]; treated as line end (x<=0, y++) to resync.
//    * Line end on y==IMG_HEIGHT-1 -> DONE; no extra beats consumed.
//    * tuser=1 beat in ACTIVE: aborted frame gives no frame_done; err_code<=3'b100,
//      pix_checksum<=tdata, x/y restart with this beat as pixel (0,0); stays ACTIVE.
//    * Simultaneous tuser and tlast: tuser handling first, then tlast evaluated at x=0.
//  - DONE: one cycle, tready 0, frame_done 1, frame_count++ -> IDLE.
//    frame_done asserted the cycle after the final beat's edge.
//  - err_code, frame_err, pix_checksum hold from frame_done until next SOF accepted in IDLE.
//  - IMG_WIDTH==1 not supported; x counter width $clog2(IMG_WIDTH), y $clog2(IMG_HEIGHT) min 1.
// CONFIGURATION
//  AXIS_SINK_THROTTLE_EN defined: 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset)
//    steps every cycle; when throttle=1, tready forced 0 whenever LFSR[1:0]==2'b00 (~1 in 4
//    cycles); throttle=0 behaves as undefined case. Checksum/framing results unaffected.
//  Undefined: no LFSR, throttle port present but ignored; tready 1 in IDLE/ACTIVE, 0 in DONE.
// TESTING (bench overrides IMG_WIDTH=4, IMG_HEIGHT=2)
//  1 SOF beat data 1, then 2..8 with tlast on 4th/8th beat -> frame_done one pulse 1 cycle after
//    beat 8, pix_checksum 36, err_code 000, frame_count 1.
//  2 Three beats tuser=0 (data 0xFF) before SOF, then frame of test 1 -> checksum 36, err 000.
//  3 Frame with tlast on beat 3 (x=2), remaining beats aligned to new line -> err_code 001,
//    frame_err 1, frame_done after line 2 completes.
//  4 Frame omits tlast on beat 4 -> err_code 010, frame still done after 8 beats.
//  5 tuser=1 on beat 6 of a frame, then 7 more beats proper framing -> no done for aborted
//    frame, err_code 100, one frame_done, frame_count increments by 1.
//  6 areset pulsed mid-frame (after beat 5) -> tready 0, frame_count 0, checksum 0 same cycle;
//    clean frame afterwards yields test 1 results. With AXIS_SINK_THROTTLE_EN, throttle=1,
//    tvalid held high: no beat accepted while tready 0, checksum still 36.

Source files
------------

// File: rtl/axis_video_frame_sink.sv
// AXI4-Stream video frame sink: checks SOF/EOL framing, counts frames, sums pixels per frame.
// Optional pseudo-random backpressure: define AXIS_SINK_THROTTLE_EN.
module axis_video_frame_sink #(
   parameter int IMG_WIDTH     = 640,
   parameter int IMG_HEIGHT    = 480,
   parameter int IO_DATA_WIDTH = 24
) (
   input  logic                     ap_clk,
   input  logic                     areset,
   input  logic [IO_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   input  logic                     s_axis_tuser,
   input  logic                     throttle,
   output logic                     frame_done,
   output logic                     frame_err,
   output logic [2:0]               err_code,
   output logic [15:0]              frame_count,
   output logic [31:0]              pix_checksum
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] x_q, x_d, x_eff;
   logic [YW-1:0] y_q, y_d, y_eff;
   logic [2:0]    err_q, err_d;
   logic [31:0]   sum_q, sum_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          tready_q, tready_d;
   logic          done_q, ferr_q;
   logic          beat, take, stall;

`ifdef AXIS_SINK_THROTTLE_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16/14/13/11
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign stall  = throttle && (lfsr_d[1:0] == 2'b00);

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end
`else
   logic unused_throttle;
   assign unused_throttle = throttle;
   assign stall           = 1'b0;
`endif

   assign beat = s_axis_tvalid & tready_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = err_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      x_eff   = x_q;
      y_eff   = y_q;
      take    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (beat && s_axis_tuser) begin
               take  = 1'b1;
               err_d = 3'b000;
               sum_d = 32'(s_axis_tdata);
               x_eff = '0;
               y_eff = '0;
            end
         end
         S_ACTIVE: begin
            if (beat) begin
               take = 1'b1;
               // A new SOF abandons the current frame and restarts at pixel (0,0).
               if (s_axis_tuser) begin
                  err_d = 3'b100;
                  sum_d = 32'(s_axis_tdata);
                  x_eff = '0;
                  y_eff = '0;
               end else begin
                  sum_d = sum_q + 32'(s_axis_tdata);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (take) begin
         state_d = S_ACTIVE;
         if (x_eff == X_LAST || s_axis_tlast) begin
            // An early tlast is still a line end so the sink resyncs to the source.
            if (!s_axis_tlast)        err_d[1] = 1'b1;
            else if (x_eff != X_LAST) err_d[0] = 1'b1;
            x_d = '0;
            if (y_eff == Y_LAST) begin
               state_d = S_DONE;
               y_d     = '0;
               cnt_d   = cnt_q + 16'd1;
            end else begin
               y_d = y_eff + YW'(1);
            end
         end else begin
            x_d = x_eff + XW'(1);
            y_d = y_eff;
         end
      end

      tready_d = (state_d != S_DONE) && !stall;
   end

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         err_q    <= '0;
         sum_q    <= '0;
         cnt_q    <= '0;
         tready_q <= 1'b0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         err_q    <= err_d;
         sum_q    <= sum_d;
         cnt_q    <= cnt_d;
         tready_q <= tready_d;
         done_q   <= (state_d == S_DONE);
         ferr_q   <= |err_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign frame_done    = done_q;
   assign frame_err     = ferr_q;
   assign err_code      = err_q;
   assign frame_count   = cnt_q;
   assign pix_checksum  = sum_q;

endmodule
